fp32_result_collector: RTL and testbench
========================================

# fp32_result_collector

Downstream consumer of the FP32 multiplier. It captures each product on the multiplier's one-cycle `ready` strobe and classifies it as NaN, infinity, zero, subnormal and/or negative. It buffers product and class in a small FIFO and presents them on a valid/ready stream so slower logic never misses a result. It also keeps saturating result and drop counters and a sticky overflow flag.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: width of `result_count` and `drop_count`.
- `clock`  in  1: rising-edge clock.
- `nreset`  in  1: reset, asynchronous, active-low.
- `in_product`  in  32: FP32 word from the multiplier; valid while `in_ready` is high.
- `in_ready`  in  1: multiplier result strobe.
- `clear`  in  1: synchronous flush; clears FIFO, counters and `overflow`.
- `out_data`  out  32: head-of-FIFO product.
- `out_class`  out  5: `{nan, inf, zero, sub, neg}` for `out_data`.
- `out_valid`  out  1: head entry is valid.
- `out_ready`  in  1: consumer accepts head.
- `level`  out  $clog2(DEPTH)+1: number of occupied entries.
- `overflow`  out  1: sticky; set when a result is dropped.
- `result_count`  out  CNT_W: results seen (accepted plus dropped); saturates.
- `drop_count`  out  CNT_W: results dropped while full; saturates.

## Operation
- **Capture on edge.** A capture event is `in_ready` high in a cycle where it was low the previous cycle, using a registered `in_ready_q` that resets to 0. `in_ready` held high for several cycles counts once.
- **Classification**, from exponent `e = [30:23]` and mantissa `m = [22:0]`:
  - nan = (e == 8'hFF) & (m != 0)
  - inf = (e == 8'hFF) & (m == 0)
  - zero = (e == 0) & (m == 0)
  - sub = (e == 0) & (m != 0)
  - neg = bit 31, for every class including NaN.
  - The multiplier's canonical NaN `32'h7F80_4F54` classifies as nan only.
- **Push.** A capture event pushes `{in_product, class}` if there is space. Space exists when `level < DEPTH`, or when `level == DEPTH` and a pop happens in the same cycle.
- **Drop.** A capture event with no space discards the data, sets `overflow` and increments `drop_count`.
- **Pop.** A pop occurs when `out_valid & out_ready`.
- **Counting.** `result_count` increments on every capture event not coinciding with `clear`. Both counters hold at all ones.
- **Clear.** `clear` wins over a simultaneous capture and pop. The capture is neither stored nor counted. After the edge, `level` is 0 and the counters and `overflow` are zero.
- **FIFO.** Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `level` is tracked separately so full and empty are unambiguous.
- **Reset values.** `out_valid` 0, `level` 0, `overflow` 0, both counters 0, `out_data` 0, `out_class` 0. Pointers are 0 and `in_ready_q` is 0. Reset mid-stream discards all buffered entries.

## Timing
- **Capture latency.** Data captured at edge N is visible on `out_data` and `out_class` with `out_valid` = 1 after edge N, when the FIFO was empty. Latency is 1 cycle; there is no combinational path from `in_ready` to the outputs.
- **Stable head.** `out_data` and `out_class` are read combinationally from the head entry. They are stable while `out_valid & !out_ready`.
- **Throughput.** One push and one pop per cycle. The multiplier delivers at most one result per 4 cycles.
- **Pop then refill.** A pop at edge N with `level == 1` and no push makes `out_valid` 0 after N.
- **Push and pop together.** Simultaneous push and pop leaves `level` unchanged.

## Structure
- Package `fp32_pkg` holds:
  - field-width localparams (sign, 8-bit exponent, 23-bit mantissa) and `FP32_CANON_NAN = 32'h7F80_4F54`;
  - `typedef struct packed {logic nan, inf, zero, sub, neg;} fp32_class_t`;
  - `FP32_POS_INF`, `FP32_NEG_INF` constants.
- Sub-module `fp32_classify`: combinational, 32-bit word in, `fp32_class_t` out. It is reusable by the upstream operand path.
- FIFO storage, pointers, edge detect and counters live in the top module.

## Test plan
1. **Basic capture.** Reset, then pulse `in_ready` for 1 cycle with `in_product = 32'h4040_0000` (3.0). Expect `out_valid` = 1 next cycle, `out_data = 32'h4040_0000`, `out_class = 5'b00000`; pop and see `level` return to 0.
2. **Classes.** Send `32'h7F80_4F54`, `32'hFF80_0000`, `32'h8000_0000`, `32'h0000_0001`. Expect classes `5'b10000`, `5'b01001`, `5'b00101`, `5'b00010`, in order.
3. **Overflow.** Hold `out_ready` = 0 and send DEPTH+2 = 6 strobes. Expect `level` = 4, `overflow` = 1, `drop_count` = 2, `result_count` = 6, and the first 4 words drain in order.
4. **Full with simultaneous pop.** With `level == DEPTH`, assert `out_ready` in the same cycle as a strobe. Expect no drop, `level` stays 4 and the new word is last out.
5. **Held strobe.** Hold `in_ready` high for 3 cycles. Expect exactly one push and `result_count` = 1.
6. **Clear and reset.** Assert `clear` on the same cycle as a strobe with 2 entries buffered. Expect `level` 0, counters 0, `overflow` 0, nothing stored. Then assert `nreset` low mid-stream and check that all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, notable encodings and the
// per-word classification record used by the collector and the operand path.
package fp32_pkg;

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MAN_W    = 23;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7F80_4F54;
  localparam logic [31:0] FP32_POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] FP32_NEG_INF   = 32'hFF80_0000;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
    logic neg;
  } fp32_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier.
// Ports:
//   word - FP32 encoding to classify
//   cls  - {nan, inf, zero, sub, neg}; neg is the raw sign bit for every class
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] word,
  output fp32_class_t cls
);

  logic [FP32_EXP_W-1:0] exponent;
  logic [FP32_MAN_W-1:0] mantissa;
  logic                  exp_max;
  logic                  exp_min;
  logic                  man_zero;

  assign exponent = word[FP32_MAN_W +: FP32_EXP_W];
  assign mantissa = word[FP32_MAN_W-1:0];
  assign exp_max  = (exponent == '1);
  assign exp_min  = (exponent == '0);
  assign man_zero = (mantissa == '0);

  assign cls.nan  = exp_max & ~man_zero;
  assign cls.inf  = exp_max & man_zero;
  assign cls.zero = exp_min & man_zero;
  assign cls.sub  = exp_min & ~man_zero;
  assign cls.neg  = word[FP32_SIGN_BIT];

endmodule

// File: rtl/fp32_result_collector.sv
// Collects FP32 multiplier results on the rising edge of the in_ready strobe,
// classifies them and buffers {product, class} in a small FIFO presented on a
// valid/ready stream. Keeps saturating result/drop counters and a sticky
// overflow flag.
// Ports:
//   clock, nreset             - clock, async active-low reset
//   in_product, in_ready      - multiplier result and its strobe
//   clear                     - synchronous flush of FIFO, counters, overflow
//   out_data, out_class       - head-of-FIFO entry (zero when empty)
//   out_valid, out_ready      - output stream handshake
//   level                     - occupied entries
//   overflow                  - sticky, set when a result is dropped
//   result_count, drop_count  - saturating counters
module fp32_result_collector
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic [31:0]              in_product,
  input  logic                     in_ready,
  input  logic                     clear,
  output logic [31:0]              out_data,
  output logic [4:0]               out_class,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         result_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic              in_ready_q;
  logic              capture;
  logic              pop;
  logic              space;
  logic              push;
  logic              drop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  fp32_class_t       in_class;

  logic [31:0]       data_mem  [DEPTH];
  fp32_class_t       class_mem [DEPTH];

  fp32_classify u_classify (
    .word (in_product),
    .cls  (in_class)
  );

  assign capture   = in_ready & ~in_ready_q;
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still has room when the head leaves in the same cycle.
  assign space     = (level < LVL_FULL) | pop;
  assign push      = capture & space & ~clear;
  assign drop      = capture & ~space & ~clear;

  // Gated so the head reads as zero when empty, including out of reset.
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_class = out_valid ? class_mem[rd_ptr] : '0;

  // Edge detector keeps tracking in_ready through clear so a strobe held
  // across a clear is not seen as a fresh capture afterwards.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) in_ready_q <= 1'b0;
    else         in_ready_q <= in_ready;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr]  <= in_product;
      class_mem[wr_ptr] <= in_class;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      overflow     <= 1'b0;
      result_count <= '0;
      drop_count   <= '0;
    end else if (clear) begin
      overflow     <= 1'b0;
      result_count <= '0;
      drop_count   <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (capture && result_count != CNT_MAX) result_count <= result_count + CNT_W'(1);
      if (drop && drop_count != CNT_MAX)      drop_count   <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp32_result_collector.sv
// Self-checking bench for fp32_result_collector: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_fp32_result_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                 clock;
  logic                 nreset;
  logic [31:0]          in_product;
  logic                 in_ready;
  logic                 clear;
  logic [31:0]          out_data;
  logic [4:0]           out_class;
  logic                 out_valid;
  logic                 out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                 overflow;
  logic [CNT_W-1:0]     result_count;
  logic [CNT_W-1:0]     drop_count;

  int checks = 0;
  int errors = 0;

  logic [36:0] mq[$];
  int          m_rc;
  int          m_dc;
  bit          m_ovf;
  bit          m_prev;

  fp32_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .in_product   (in_product),
    .in_ready     (in_ready),
    .clear        (clear),
    .out_data     (out_data),
    .out_class    (out_class),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .result_count (result_count),
    .drop_count   (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] ref_class(input logic [31:0] w);
    int unsigned e, m;
    e = (w >> 23) % 256;
    m = w % (1 << 23);
    return {(e == 255) && (m != 0), (e == 255) && (m == 0),
            (e == 0) && (m == 0), (e == 0) && (m != 0), w >= 32'h8000_0000};
  endfunction

  function automatic logic [31:0] rand_word();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom_range(1, 23'h7F_FFFF));
    case ($urandom_range(0, 4))
      0:       return {s, 8'hFF, 23'h0};
      1:       return {s, 8'hFF, m};
      2:       return {s, 8'h00, 23'h0};
      3:       return {s, 8'h00, m};
      default: begin
        e = 8'($urandom_range(1, 254));
        return {s, e, m};
      end
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rc = 0; m_dc = 0; m_ovf = 0; m_prev = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit cap, pp;
    if (!nreset) begin
      model_reset();
      return;
    end
    cap = in_ready && !m_prev;
    pp  = (mq.size() != 0) && out_ready;
    m_prev = in_ready;
    if (clear) begin
      mq.delete();
      m_rc = 0; m_dc = 0; m_ovf = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (cap) begin
        if (m_rc < MAXC) m_rc++;
        if (mq.size() < DEPTH) mq.push_back({in_product, ref_class(in_product)});
        else begin
          m_ovf = 1;
          if (m_dc < MAXC) m_dc++;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] w);
    in_product = w;
    in_ready   = 1'b1;
    cycle();
    in_ready   = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (result_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", result_count, drop_count); end
    checks++; if (out_data !== 32'h0 || out_class !== 5'h0) begin errors++; $display("FAIL reset_head got %h/%b want 0/0", out_data, out_class); end
  endtask

  task automatic test_basic_capture();
    out_ready  = 1'b0;
    in_product = 32'h4040_0000;
    in_ready   = 1'b1;
    cycle();
    in_ready   = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 32'h4040_0000) begin errors++; $display("FAIL basic_data got %h want 40400000", out_data); end
    checks++; if (out_class !== 5'b00000) begin errors++; $display("FAIL basic_class got %b want 00000", out_class); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (level !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop level %0d valid %0b want 0 0", level, out_valid); end
    repeat (2) cycle();
  endtask

  task automatic test_classes();
    logic [31:0] words [4];
    logic [4:0]  cls   [4];
    words = '{32'h7F80_4F54, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001};
    cls   = '{5'b10000, 5'b01001, 5'b00101, 5'b00010};
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(words[i]);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== words[i] || out_class !== cls[i]) begin
        errors++;
        $display("FAIL class_%0d got %h/%b want %h/%b", i, out_data, out_class, words[i], cls[i]);
      end
      out_ready = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] words [6];
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      words[i] = rand_word();
      send(words[i]);
    end
    checks++; if (level !== DEPTH) begin errors++; $display("FAIL ovf_level got %0d want %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (drop_count !== 2 || result_count !== 6) begin errors++; $display("FAIL ovf_counts got %0d/%0d want 2/6", drop_count, result_count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== words[i]) begin
        errors++;
        $display("FAIL ovf_drain_%0d got %h valid %0b want %h", i, out_data, out_valid, words[i]);
      end
      out_ready = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got valid %0b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    logic [31:0] words [5];
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      words[i] = rand_word();
      send(words[i]);
    end
    words[4]   = rand_word();
    in_product = words[4];
    in_ready   = 1'b1;
    out_ready  = 1'b1;
    cycle();
    in_ready   = 1'b0;
    out_ready  = 1'b0;
    checks++; if (level !== DEPTH) begin errors++; $display("FAIL fullpop_level got %0d want %0d", level, DEPTH); end
    checks++; if (drop_count !== 0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_drop got %0d ovf %0b want 0 0", drop_count, overflow); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (out_data !== words[i]) begin
        errors++;
        $display("FAIL fullpop_order_%0d got %h want %h", i, out_data, words[i]);
      end
      out_ready = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_held_strobe();
    do_clear();
    out_ready  = 1'b0;
    in_product = rand_word();
    in_ready   = 1'b1;
    repeat (3) cycle();
    in_ready   = 1'b0;
    cycle();
    checks++; if (result_count !== 1 || level !== 1) begin errors++; $display("FAIL held_strobe count %0d level %0d want 1 1", result_count, level); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_clear();
    out_ready = 1'b0;
    repeat (20) send(rand_word());
    checks++; if (result_count !== MAXC || drop_count !== MAXC) begin errors++; $display("FAIL saturate got %0d/%0d want %0d/%0d", result_count, drop_count, MAXC, MAXC); end
    checks++; if (level !== DEPTH || overflow !== 1'b1) begin errors++; $display("FAIL saturate_state level %0d ovf %0b want %0d 1", level, overflow, DEPTH); end
  endtask

  task automatic test_clear();
    do_clear();
    out_ready = 1'b0;
    repeat (6) send(rand_word());
    out_ready = 1'b1;
    repeat (2) cycle();
    out_ready = 1'b0;
    checks++; if (level !== 2 || overflow !== 1'b1) begin errors++; $display("FAIL clear_setup level %0d ovf %0b want 2 1", level, overflow); end
    in_product = rand_word();
    in_ready   = 1'b1;
    out_ready  = 1'b1;
    clear      = 1'b1;
    cycle();
    clear      = 1'b0;
    in_ready   = 1'b0;
    out_ready  = 1'b0;
    checks++; if (level !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear_level got %0d valid %0b want 0 0", level, out_valid); end
    checks++; if (result_count !== 0 || drop_count !== 0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_counts got %0d/%0d ovf %0b want 0/0 0", result_count, drop_count, overflow); end
    cycle();
    checks++; if (level !== 0) begin errors++; $display("FAIL clear_nostore got level %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    out_ready = 1'b0;
    repeat (2) send(rand_word());
    in_product = rand_word();
    in_ready   = 1'b1;
    #2 nreset = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0 || level !== 0) begin errors++; $display("FAIL midreset_fifo valid %0b level %0d want 0 0", out_valid, level); end
    checks++; if (result_count !== 0 || drop_count !== 0 || overflow !== 1'b0) begin errors++; $display("FAIL midreset_counts got %0d/%0d ovf %0b want 0/0 0", result_count, drop_count, overflow); end
    checks++; if (out_data !== 32'h0 || out_class !== 5'h0) begin errors++; $display("FAIL midreset_head got %h/%b want 0/0", out_data, out_class); end
    in_ready = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    cycle();
    checks++; if (level !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL postreset level %0d valid %0b want 0 0", level, out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] exp_data;
    logic [4:0]  exp_class;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      exp_data  = (mq.size() != 0) ? mq[0][36:5] : 32'h0;
      exp_class = (mq.size() != 0) ? mq[0][4:0]  : 5'h0;
      checks++;
      if (out_valid !== (mq.size() != 0) || level !== mq.size() || out_data !== exp_data || out_class !== exp_class) begin
        errors++;
        $display("FAIL rand_head_%0d got v%0b l%0d %h/%b want v%0b l%0d %h/%b", i, out_valid, level, out_data, out_class,
                 mq.size() != 0, mq.size(), exp_data, exp_class);
      end
      checks++;
      if (result_count !== m_rc || drop_count !== m_dc || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_stats_%0d got %0d/%0d ovf %0b want %0d/%0d ovf %0b", i, result_count, drop_count, overflow, m_rc, m_dc, m_ovf);
      end
      clear      = ($urandom_range(0, 39) == 0);
      in_ready   = ($urandom_range(0, 2) == 0);
      out_ready  = ($urandom_range(0, 2) == 0);
      in_product = rand_word();
      cycle();
    end
    clear     = 1'b0;
    in_ready  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    nreset     = 1'b0;
    in_product = 32'h0;
    in_ready   = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    test_reset();
    test_basic_capture();
    test_classes();
    test_overflow();
    test_full_pop();
    test_held_strobe();
    test_saturation();
    test_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
